// File: rtl/prio_irq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : prio_irq                                                         |
// | Brief   : Registered priority interrupt controller, edge/level per line,   |
// |           masked pending register and req/ack vector handshake.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module prio_irq #(
    parameter int                    WIDTH = 4,
    parameter logic [(1<<WIDTH)-1:0] EDGE  = '1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [(1<<WIDTH)-1:0]   irq,
    input  logic                    mask_wr,
    input  logic [(1<<WIDTH)-1:0]   mask_din,
    output logic [(1<<WIDTH)-1:0]   mask,
    output logic [(1<<WIDTH)-1:0]   pending,
    output logic                    req,
    output logic [WIDTH-1:0]        vector,
    input  logic                    ack
);

    localparam int N = 1 << WIDTH;

    logic [N-1:0]     r_prev_q;
    logic [N-1:0]     r_pending_q;
    logic [N-1:0]     w_pending_d;
    logic [N-1:0]     r_mask_q;
    logic [N-1:0]     w_mask_d;
    logic             r_req_q;
    logic             w_req_d;
    logic [WIDTH-1:0] r_vector_q;
    logic [WIDTH-1:0] w_vector_d;
    logic [N-1:0]     w_eff;
    logic [WIDTH-1:0] w_sel;
    logic             w_accept;

    assign w_accept = r_req_q & ack;

    // A fresh rising edge wins over the ack-clear so no edge is ever lost.
    always_comb begin
        w_pending_d = r_pending_q;
        for (int i = 0; i < N; i++) begin
            if (EDGE[i]) begin
                w_pending_d[i] = (irq[i] & ~r_prev_q[i])
                               | (r_pending_q[i] & ~(w_accept & (r_vector_q == WIDTH'(i))));
            end else begin
                w_pending_d[i] = irq[i];
            end
        end
    end

    always_comb begin
        w_eff = r_pending_q & r_mask_q;
        w_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (w_eff[i]) begin
                w_sel = WIDTH'(i);
            end
        end
    end

    assign w_mask_d = mask_wr ? mask_din : r_mask_q;

    // After an accept, req idles one cycle so the next pick sees updated pending.
    always_comb begin
        w_req_d    = r_req_q;
        w_vector_d = r_vector_q;
        if (w_accept) begin
            w_req_d = 1'b0;
        end else if (!r_req_q) begin
            w_req_d    = |w_eff;
            w_vector_d = w_sel;
        end
    end

    always_ff @(posedge clk) begin
        r_prev_q <= irq;
        if (reset) begin
            r_pending_q <= '0;
            r_mask_q    <= '0;
            r_req_q     <= 1'b0;
            r_vector_q  <= '0;
        end else begin
            r_pending_q <= w_pending_d;
            r_mask_q    <= w_mask_d;
            r_req_q     <= w_req_d;
            r_vector_q  <= w_vector_d;
        end
    end

    assign mask    = r_mask_q;
    assign pending = r_pending_q;
    assign req     = r_req_q;
    assign vector  = r_vector_q;

endmodule
`default_nettype wire

// File: tb/tb_prio_irq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_prio_irq                                                      |
// | Brief   : Scoreboard bench for prio_irq with a behavioural channel model.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_prio_irq;

    localparam int          WIDTH  = 4;
    localparam int          N      = 1 << WIDTH;
    localparam logic [15:0] EDGE_P = 16'hFF7F;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     irq = '0;
    logic             mask_wr = 1'b0;
    logic [N-1:0]     mask_din = '0;
    logic [N-1:0]     mask;
    logic [N-1:0]     pending;
    logic             req;
    logic [WIDTH-1:0] vector;
    logic             ack = 1'b0;

    prio_irq #(.WIDTH(WIDTH), .EDGE(EDGE_P)) dut (
        .clk(clk), .reset(reset), .irq(irq), .mask_wr(mask_wr),
        .mask_din(mask_din), .mask(mask), .pending(pending),
        .req(req), .vector(vector), .ack(ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             req;
        logic [WIDTH-1:0] vec;
        logic [N-1:0]     pend;
        logic [N-1:0]     mask;
    } exp_t;

    exp_t exp_q[$];
    int   vec_log[$];
    int   tests = 0;
    int   fails = 0;

    // Behavioural model state: what the controller should show after each edge.
    bit [N-1:0] m_prev = '0;
    bit [N-1:0] m_pend = '0;
    bit [N-1:0] m_mask = '0;
    bit         m_req  = 1'b0;
    int         m_vec  = 0;
    bit [N-1:0] cur_irq = '0;

    function automatic int highest(input bit [N-1:0] v);
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_step(input bit [N-1:0] irq_v, input bit mwr, input bit [N-1:0] mdin,
                              input bit ack_v, input bit rst_v);
        bit [N-1:0] eff;
        bit [N-1:0] np;
        if (rst_v) begin
            m_pend = '0; m_mask = '0; m_req = 1'b0; m_vec = 0;
        end else begin
            eff = m_pend & m_mask;
            for (int i = 0; i < N; i++) begin
                if (!EDGE_P[i])                        np[i] = irq_v[i];
                else if (irq_v[i] && !m_prev[i])       np[i] = 1'b1;
                else if (m_req && ack_v && m_vec == i) np[i] = 1'b0;
                else                                   np[i] = m_pend[i];
            end
            if (m_req && ack_v) begin
                m_req = 1'b0;
            end else if (!m_req) begin
                m_req = (eff != 0);
                m_vec = highest(eff);
            end
            if (mwr) m_mask = mdin;
            m_pend = np;
        end
        m_prev = irq_v;
    endtask

    task automatic step(input bit [N-1:0] irq_v, input bit mwr, input bit [N-1:0] mdin,
                        input bit ack_v, input bit rst_v);
        exp_t e;
        @(negedge clk);
        irq = irq_v; mask_wr = mwr; mask_din = mdin; ack = ack_v; reset = rst_v;
        cur_irq = irq_v;
        model_step(irq_v, mwr, mdin, ack_v, rst_v);
        e.req = m_req; e.vec = WIDTH'(m_vec); e.pend = m_pend; e.mask = m_mask;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input bit auto_ack);
        for (int k = 0; k < n; k++) step(cur_irq, 1'b0, '0, auto_ack & m_req, 1'b0);
    endtask

    task automatic set_mask(input bit [N-1:0] m);
        step(cur_irq, 1'b1, m, 1'b0, 1'b0);
    endtask

    task automatic chk_log(input string name, input int idx, input int expv);
        if (idx < vec_log.size()) chk(name, vec_log[idx], expv);
        else chk({name, "_missing"}, -1, expv);
    endtask

    // Monitor: compares every post-edge DUT state with the queued expectation.
    initial begin
        exp_t e;
        logic prev_req = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("req", int'(req), int'(e.req));
                if (e.req) chk("vector", int'(vector), int'(e.vec));
                chk("pending", int'(pending), int'(e.pend));
                chk("mask", int'(mask), int'(e.mask));
            end
            if (req === 1'b1 && prev_req !== 1'b1) vec_log.push_back(int'(vector));
            prev_req = req;
        end
    end

    initial begin
        step('0, 1'b0, '0, 1'b0, 1'b1);
        step('0, 1'b0, '0, 1'b0, 1'b1);
        set_mask(16'hFFFF);

        // Single pulse on 3: held without ack, then acked.
        vec_log.delete();
        step(16'h0008, 1'b0, '0, 1'b0, 1'b0);
        step(16'h0000, 1'b0, '0, 1'b0, 1'b0);
        idle(6, 1'b0);
        step('0, 1'b0, '0, 1'b1, 1'b0);
        idle(3, 1'b0);
        chk("s1_count", vec_log.size(), 1);
        chk_log("s1_vec", 0, 3);

        // Simultaneous 2, 9, 15 with continuous ack.
        vec_log.delete();
        step(16'h8204, 1'b0, '0, 1'b0, 1'b0);
        step(16'h0000, 1'b0, '0, 1'b0, 1'b0);
        idle(10, 1'b1);
        chk("s2_count", vec_log.size(), 3);
        chk_log("s2_first", 0, 15);
        chk_log("s2_second", 1, 9);
        chk_log("s2_third", 2, 2);
        chk("s2_pending", int'(pending), 0);

        // Mask gating of channel 5.
        vec_log.delete();
        set_mask(16'h0000);
        step(16'h0020, 1'b0, '0, 1'b0, 1'b0);
        step(16'h0000, 1'b0, '0, 1'b0, 1'b0);
        idle(10, 1'b0);
        chk("s3_masked", vec_log.size(), 0);
        set_mask(16'h0020);
        idle(2, 1'b0);
        chk_log("s3_vec", 0, 5);
        idle(3, 1'b1);
        set_mask(16'hFFFF);

        // Level channel 7.
        vec_log.delete();
        step(16'h0080, 1'b0, '0, 1'b0, 1'b0);
        idle(8, 1'b1);
        step(16'h0000, 1'b0, '0, m_req, 1'b0);
        idle(4, 1'b1);
        chk_log("s4_first", 0, 7);
        chk_log("s4_again", 1, 7);
        chk("s4_req_low", int'(req), 0);

        // Edge on 4 racing its own ack.
        vec_log.delete();
        step(16'h0010, 1'b0, '0, 1'b0, 1'b0);
        step(16'h0000, 1'b0, '0, 1'b0, 1'b0);
        step(16'h0000, 1'b0, '0, 1'b0, 1'b0);
        step(16'h0010, 1'b0, '0, 1'b1, 1'b0);
        step(16'h0000, 1'b0, '0, 1'b0, 1'b0);
        chk("s5_pend4", int'(pending[4]), 1);
        idle(4, 1'b1);
        chk("s5_count", vec_log.size(), 2);
        chk_log("s5_second", 1, 4);

        // Reset mid-handshake with irq 6 held high.
        step(16'h0040, 1'b0, '0, 1'b0, 1'b0);
        idle(2, 1'b0);
        step(16'h0040, 1'b0, '0, 1'b0, 1'b1);
        vec_log.delete();
        set_mask(16'hFFFF);
        idle(6, 1'b0);
        chk("s6_no_req", vec_log.size(), 0);
        step(16'h0000, 1'b0, '0, 1'b0, 1'b0);
        step(16'h0040, 1'b0, '0, 1'b0, 1'b0);
        idle(3, 1'b1);
        chk_log("s6_vec", 0, 6);

        // Randomised traffic.
        for (int k = 0; k < 500; k++) begin
            bit [N-1:0] r_irq;
            bit         r_mwr;
            bit         r_rst;
            r_irq = N'($urandom & $urandom & $urandom);
            r_mwr = ($urandom_range(15) == 0);
            r_rst = ($urandom_range(99) == 0);
            step(r_irq, r_mwr, N'($urandom | $urandom), m_req & $urandom_range(1), r_rst);
        end

        @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prio_irq.md
# prio_irq

Registered, parametrised interrupt priority controller that generalises the combinational priority encoder. It accepts 2^WIDTH request lines, each configurable as rising-edge or level sensitive, and latches them into a pending register. A software-writable mask gates the pending lines. The highest-numbered unmasked pending line is presented to the CPU through a req/ack handshake. It sits between peripheral interrupt sources and the CPU's interrupt entry logic.

## Interface
- WIDTH, 4: log2 of channel count; N = 1<<WIDTH channels (N ≥ 2).
- EDGE, all ones (N bits): per-channel mode; bit i = 1 means rising-edge sensitive, bit i = 0 means level sensitive.
- clk  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- irq  in  N  interrupt sources, synchronous to clk.
- mask_wr  in  1  load mask from mask_din this cycle.
- mask_din  in  N  new mask value; bit = 1 enables the channel.
- mask  out  N  current mask register.
- pending  out  N  current pending register.
- req  out  1  interrupt presented; registered.
- vector  out  WIDTH  channel number of the presented interrupt; registered; valid only while req = 1.
- ack  in  1  CPU accepts the presented vector; ignored unless req = 1.

## Operation
- Registers: prev[N], pending[N], mask[N], req, vector. All are updated on the same edge from pre-edge values.
- Edge channel i (EDGE[i] = 1):
  - set when irq[i] & ~prev[i];
  - clear when req & ack & vector == i;
  - otherwise hold;
  - set beats clear in the same cycle, so a new edge is never lost.
- Level channel i (EDGE[i] = 0): pending[i] <= irq[i] every cycle; ack does not clear it.
- prev <= irq every cycle, including during reset. A line already high at reset release does not generate an edge.
- mask <= mask_din when mask_wr = 1, otherwise hold. Masking does not clear pending.
- eff = pending & mask. sel = index of the highest set bit of eff, or 0 if none. Highest index has highest priority.
- Output register, in priority order:
  - req & ack: req <= 0 and vector holds. This forces one idle cycle so the selection after an ack sees the updated pending.
  - req & ~ack: req and vector hold. The presentation stays stable even if the channel is later masked or a level line drops.
  - ~req: req <= |eff and vector <= sel.
- ack while req = 0 has no effect.
- reset:
  - pending, mask, req and vector go to 0; prev loads irq;
  - irq, mask_wr and ack in the reset cycle are ignored;
  - because the mask resets to 0, no request is presented until software writes the mask.

## Timing
- irq edge sampled at edge t: pending set after t, req/vector valid after t+1. Irq-to-req latency is 2 clocks.
- mask_wr at edge t: a newly enabled pending channel raises req after t+1.
- ack accepted at edge t: req is low for the cycle after t. The next req can rise after t+1 at the earliest. Back-to-back service gives at most one vector per 2 clocks.
- pending and mask are visible 1 clock after the causing edge. req and vector are never combinational from inputs.
- Reset applied mid-handshake drops req on the next edge. No ack is required and no pending state is retained.

## Test plan
- WIDTH = 4, all edge channels, mask = 0xFFFF, 1-cycle pulse on irq[3]:
  - req rises 2 clocks later with vector = 3 and holds for 5 cycles without ack;
  - ack for one cycle gives req = 0 and pending[3] = 0 next cycle.
- Simultaneous pulses on irq[2], irq[9], irq[15], with ack asserted whenever req = 1:
  - vectors appear in order 15, 9, 2;
  - req is low for exactly 1 cycle between each;
  - pending ends at 0.
- Mask gating, mask = 0, pulse irq[5]:
  - pending = 0x0020 and req stays 0 for 10 cycles;
  - writing mask = 0x0020 raises req after 2 clocks with vector = 5.
- EDGE = 0xFF7F (channel 7 level), mask = 0xFFFF, irq[7] held high:
  - vector = 7; after ack, req re-asserts vector 7 following the 1 idle cycle;
  - dropping irq[7] then acking leaves req = 0.
- Edge-channel race: a new irq[4] edge in the same cycle that ack accepts vector 4:
  - pending[4] stays 1;
  - vector 4 is presented again after the idle cycle.
- irq[6] held high through reset, then a reset pulse asserted while req = 1 with vector = 6:
  - outputs are 0 next cycle;
  - after release with mask = 0xFFFF, no request arises from the held-high irq[6];
  - a subsequent fall and rise of irq[6] produces vector 6.
